// File: rtl/matrix_4x4_serial_out.sv
// Parallel-to-serial output stage: captures a 4x4 result matrix and streams one element per beat.
// Latency 1 cycle from accept to beat 0; beats are held while ready_in is low; no matrix overlap.
module matrix_4x4_serial_out #(
  parameter int W         = 12,
  parameter int ROW_MAJOR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [3:0][W-1:0]   cC1,
  input  logic [3:0][W-1:0]   cC2,
  input  logic [3:0][W-1:0]   cC3,
  input  logic [3:0][W-1:0]   cC4,
  output logic                ready_out,
  output logic                valid_out,
  output logic [W-1:0]        c_out,
  output logic [3:0]          idx_out,
  output logic                last_out,
  input  logic                ready_in
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_q, state_d;
  logic [15:0][W-1:0] mat_q, mat_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [W-1:0]       c_q, c_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               last_q, last_d;
  logic               hs;

  // Matrix is stored column-major: slot col*4+row.
  function automatic logic [W-1:0] pick(input logic [15:0][W-1:0] m, input logic [3:0] k);
    if (ROW_MAJOR != 0) return m[{k[1:0], k[3:2]}];
    else                return m[k];
  endfunction

  assign hs = valid_q && ready_in;

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    valid_d = valid_q;
    ready_d = ready_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        if (valid_in && ready_q) begin
          state_d = STREAM;
          mat_d   = {cC4, cC3, cC2, cC1};
          cnt_d   = 4'd0;
          c_d     = cC1[0];
          last_d  = 1'b0;
          ready_d = 1'b0;
          valid_d = 1'b1;
        end
      end
      STREAM: begin
        if (hs) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
            cnt_d   = 4'd0;
            last_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q + 4'd1;
            c_d    = pick(mat_q, cnt_q + 4'd1);
            last_d = (cnt_q == 4'd14);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      c_q     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      last_q  <= last_d;
    end
  end

  // Data store carries no reset; it is only meaningful after an accept.
  always_ff @(posedge clk) begin
    mat_q <= mat_d;
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign c_out     = c_q;
  assign idx_out   = cnt_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_matrix_4x4_serial_out.sv
// Directed bench for matrix_4x4_serial_out; one column-major and one row-major instance share stimulus.
module tb_matrix_4x4_serial_out;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic              ready_in;
  logic [3:0][11:0]  cc1, cc2, cc3, cc4;
  logic              rdy0, vo0, last0, rdy1, vo1, last1;
  logic [11:0]       c0, c1;
  logic [3:0]        idx0, idx1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  matrix_4x4_serial_out #(.W(12), .ROW_MAJOR(0)) dut0 (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .cC1(cc1), .cC2(cc2), .cC3(cc3), .cC4(cc4),
    .ready_out(rdy0), .valid_out(vo0), .c_out(c0), .idx_out(idx0),
    .last_out(last0), .ready_in(ready_in)
  );

  matrix_4x4_serial_out #(.W(12), .ROW_MAJOR(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .cC1(cc1), .cC2(cc2), .cC3(cc3), .cC4(cc4),
    .ready_out(rdy1), .valid_out(vo1), .c_out(c1), .idx_out(idx1),
    .last_out(last1), .ready_in(ready_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cCj[r] = base + 16*(j-1) + r
  task automatic load(input int base);
    for (int r = 0; r < 4; r++) begin
      cc1[r] = 12'(base + r);
      cc2[r] = 12'(base + 16 + r);
      cc3[r] = 12'(base + 32 + r);
      cc4[r] = 12'(base + 48 + r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    load(0);
    tick(); tick();
    tests++;
    if ({vo0, rdy0, last0, idx0, c0} !== 19'd0) begin
      fails++;
      $display("FAIL reset_state: got v=%0b r=%0b l=%0b idx=%0d c=%h, want all 0", vo0, rdy0, last0, idx0, c0);
    end
    tests++;
    if (vo1 !== 1'b0 || rdy1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_state_rm: got v=%0b r=%0b, want 0 0", vo1, rdy1);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1 || vo0 !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_reset: got r0=%0b r1=%0b v=%0b, want 1 1 0", rdy0, rdy1, vo0);
    end
  endtask

  task automatic test_col_major();
    logic [11:0] e;
    load(0); valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tests++;
    if (vo0 !== 1'b1 || rdy0 !== 1'b0) begin
      fails++;
      $display("FAIL cm_accept: got v=%0b r=%0b, want 1 0", vo0, rdy0);
    end
    for (int k = 0; k < 16; k++) begin
      e = 12'(16 * (k / 4) + k % 4);
      tests++;
      if (c0 !== e || idx0 !== 4'(k) || last0 !== (k == 15) || vo0 !== 1'b1) begin
        fails++;
        $display("FAIL cm_beat%0d: got c=%0d idx=%0d last=%0b v=%0b, want c=%0d idx=%0d last=%0b v=1",
                 k, c0, idx0, last0, vo0, e, k, (k == 15));
      end
      tick();
    end
    tests++;
    if (vo0 !== 1'b0 || rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL cm_end: got v=%0b r=%0b, want 0 1", vo0, rdy0);
    end
  endtask

  task automatic test_row_major();
    logic [11:0] e;
    load(0); valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e = 12'(16 * (k % 4) + k / 4);
      tests++;
      if (c1 !== e || idx1 !== 4'(k) || last1 !== (k == 15) || vo1 !== 1'b1) begin
        fails++;
        $display("FAIL rm_beat%0d: got c=%0d idx=%0d last=%0b v=%0b, want c=%0d idx=%0d last=%0b v=1",
                 k, c1, idx1, last1, vo1, e, k, (k == 15));
      end
      tick();
    end
    tests++;
    if (vo1 !== 1'b0 || rdy1 !== 1'b1) begin
      fails++;
      $display("FAIL rm_end: got v=%0b r=%0b, want 0 1", vo1, rdy1);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat = 4'b1001;
    logic [11:0] e, prev_c;
    logic [3:0]  prev_idx;
    logic        prev_stall;
    int got, cyc;
    load(0); valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int r = 0; r < 4; r++) begin
      cc1[r] = 12'hABC; cc2[r] = 12'hABC; cc3[r] = 12'hABC; cc4[r] = 12'hABC;
    end
    got = 0; cyc = 0; prev_stall = 1'b0; prev_c = '0; prev_idx = '0;
    while (got < 16 && cyc < 80) begin
      ready_in = pat[cyc % 4];
      if (prev_stall) begin
        tests++;
        if (c0 !== prev_c || idx0 !== prev_idx || vo0 !== 1'b1) begin
          fails++;
          $display("FAIL bp_hold cyc%0d: got c=%0d idx=%0d v=%0b, want c=%0d idx=%0d v=1",
                   cyc, c0, idx0, vo0, prev_c, prev_idx);
        end
      end
      if (vo0 && ready_in) begin
        e = 12'(16 * (got / 4) + got % 4);
        tests++;
        if (c0 !== e || idx0 !== 4'(got)) begin
          fails++;
          $display("FAIL bp_beat%0d: got c=%0d idx=%0d, want c=%0d idx=%0d", got, c0, idx0, e, got);
        end
        got++;
      end
      prev_stall = vo0 && !ready_in;
      prev_c = c0; prev_idx = idx0;
      tick();
      cyc++;
    end
    tests++;
    if (got != 16 || vo0 !== 1'b0 || rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL bp_count: got handshakes=%0d v=%0b r=%0b, want 16 0 1", got, vo0, rdy0);
    end
    ready_in = 1'b1;
  endtask

  task automatic test_back_to_back();
    int acc_cyc[2];
    int na, hs, cyc;
    logic [11:0] e;
    load(100); valid_in = 1'b1; ready_in = 1'b1;
    na = 0; hs = 0; cyc = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    while (hs < 32 && cyc < 60) begin
      if (rdy0 && valid_in && na < 2) begin
        acc_cyc[na] = cyc;
        na++;
      end
      if (vo0) begin
        tests++;
        if (rdy0 !== 1'b0) begin
          fails++;
          $display("FAIL b2b_ready_low cyc%0d: got ready_out=%0b, want 0", cyc, rdy0);
        end
      end
      if (vo0 && ready_in) begin
        e = 12'((hs < 16 ? 100 : 200) + 16 * ((hs % 16) / 4) + hs % 4);
        tests++;
        if (c0 !== e) begin
          fails++;
          $display("FAIL b2b_beat%0d: got c=%0d, want %0d", hs, c0, e);
        end
        hs++;
      end
      tick();
      cyc++;
      if (na == 1) load(200);
      if (na == 2) valid_in = 1'b0;
    end
    tests++;
    if (na != 2 || acc_cyc[1] - acc_cyc[0] != 17 || hs != 32) begin
      fails++;
      $display("FAIL b2b_period: got accepts=%0d period=%0d beats=%0d, want 2 17 32",
               na, acc_cyc[1] - acc_cyc[0], hs);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_mid_reset();
    load(0); valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    tests++;
    if (c0 !== 12'd19 || idx0 !== 4'd7) begin
      fails++;
      $display("FAIL mr_beat7: got c=%0d idx=%0d, want c=19 idx=7", c0, idx0);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (vo0 !== 1'b0 || last0 !== 1'b0 || idx0 !== 4'd0 || rdy0 !== 1'b0) begin
      fails++;
      $display("FAIL mr_abort: got v=%0b l=%0b idx=%0d r=%0b, want 0 0 0 0", vo0, last0, idx0, rdy0);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (rdy0 !== 1'b1 || vo0 !== 1'b0) begin
      fails++;
      $display("FAIL mr_ready: got r=%0b v=%0b, want 1 0", rdy0, vo0);
    end
    load(300); valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tests++;
    if (vo0 !== 1'b1 || c0 !== 12'd300 || idx0 !== 4'd0) begin
      fails++;
      $display("FAIL mr_restart: got v=%0b c=%0d idx=%0d, want 1 300 0", vo0, c0, idx0);
    end
    for (int k = 0; k < 15; k++) tick();
    tests++;
    if (c0 !== 12'd351 || idx0 !== 4'd15 || last0 !== 1'b1) begin
      fails++;
      $display("FAIL mr_last: got c=%0d idx=%0d l=%0b, want 351 15 1", c0, idx0, last0);
    end
    tick();
    tests++;
    if (vo0 !== 1'b0 || rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL mr_end: got v=%0b r=%0b, want 0 1", vo0, rdy0);
    end
  endtask

  task automatic test_negative();
    for (int r = 0; r < 4; r++) begin
      cc1[r] = 12'h5A5; cc2[r] = 12'h5A5; cc3[r] = 12'h5A5; cc4[r] = 12'h5A5;
    end
    cc1[0] = 12'hC00;
    cc4[3] = 12'h3FF;
    valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tests++;
    if (c0 !== 12'hC00 || c1 !== 12'hC00) begin
      fails++;
      $display("FAIL neg_beat0: got c0=%h c1=%h, want C00 C00", c0, c1);
    end
    tick();
    tests++;
    if (c0 !== 12'h5A5) begin
      fails++;
      $display("FAIL neg_beat1: got c=%h, want 5A5", c0);
    end
    for (int k = 1; k < 15; k++) tick();
    tests++;
    if (c0 !== 12'h3FF || c1 !== 12'h3FF || last0 !== 1'b1 || last1 !== 1'b1) begin
      fails++;
      $display("FAIL neg_beat15: got c0=%h c1=%h l0=%0b l1=%0b, want 3FF 3FF 1 1", c0, c1, last0, last1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_col_major();
    test_row_major();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_negative();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
